// File: rtl/gemcsc_match_window_pkg.sv
// Shared widths, history entry layout, flag codes and span helpers for the
// GEM-CSC match window.
package gemcsc_match_window_pkg;

  localparam int MXHIST = 8;                 // history depth in bx
  localparam int MXWG   = 7;                 // ALCT key wiregroup width
  localparam int MXHS   = 8;                 // CLCT key halfstrip width
  localparam int AGE_W  = $clog2(MXHIST);    // width of an entry age
  localparam int WIN_W  = 3;                 // width of the gem_win input

  // Geometric span of one GEM object (inclusive bounds).
  typedef struct packed {
    logic [MXWG-1:0] wg_lo;
    logic [MXWG-1:0] wg_hi;
    logic [MXHS-1:0] hs_lo;
    logic [MXHS-1:0] hs_hi;
  } span_t;

  // One history entry: presence, ghost-suppression mark and span.
  typedef struct packed {
    logic  vld;
    logic  used;
    span_t span;
  } entry_t;

  // Match flag codes, listed in priority order.
  typedef enum logic [2:0] {
    FLAG_NONE            = 3'd0,
    FLAG_ALCT_CLCT_COPAD = 3'd1,
    FLAG_ALCT_CLCT_GEM   = 3'd2,
    FLAG_ALCT_CLCT       = 3'd3,
    FLAG_CLCT_COPAD      = 3'd4,
    FLAG_ALCT_COPAD      = 3'd5
  } flag_e;

  // Unsigned inclusive span test; lo > hi can never be satisfied.
  function automatic logic wg_in_span(input logic [MXWG-1:0] lo,
                                      input logic [MXWG-1:0] hi,
                                      input logic [MXWG-1:0] x);
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic hs_in_span(input logic [MXHS-1:0] lo,
                                      input logic [MXHS-1:0] hi,
                                      input logic [MXHS-1:0] x);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/gemcsc_match_window_hist.sv
// One GEM bx history (co-pads or single-layer clusters). Age 0 is the live
// input (bypass), ages 1..MXHIST-1 are registered. Entries shift one age per
// bx; a consume bit marks the entry at that age used as it moves to age+1.
module gemcsc_match_window_hist
  import gemcsc_match_window_pkg::*;
(
  input  logic                  clock,
  input  logic                  global_reset,
  input  logic                  flush,
  input  entry_t                entry,
  input  logic [MXHIST-2:0]     consume,
  output entry_t [MXHIST-1:0]   hist
);

  logic [MXHIST-1:1] vld_q;
  logic [MXHIST-1:1] used_q;
  span_t             span_q [MXHIST-1:1];

  // Control bits: shift with consume marking; flush wins over shift/consume.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      vld_q  <= '0;
      used_q <= '0;
    end else if (flush) begin
      vld_q  <= '0;
      used_q <= '0;
    end else begin
      vld_q[1]  <= entry.vld;
      used_q[1] <= entry.used | consume[0];
      for (int k = 2; k < MXHIST; k++) begin
        vld_q[k]  <= vld_q[k-1];
        used_q[k] <= used_q[k-1] | consume[k-1];
      end
    end
  end

  // Span payload: plain shift, meaningful only where vld is set.
  always_ff @(posedge clock) begin
    span_q[1] <= entry.span;
    for (int k = 2; k < MXHIST; k++) begin
      span_q[k] <= span_q[k-1];
    end
  end

  // Flat history view with the live input as age 0.
  always_comb begin
    hist[0] = entry;
    for (int k = 1; k < MXHIST; k++) begin
      hist[k].vld  = vld_q[k];
      hist[k].used = used_q[k];
      hist[k].span = span_q[k];
    end
  end

endmodule

// File: rtl/gemcsc_match_window.sv
// GEM-CSC match window: compares each bx's ALCT/CLCT against the co-pad and
// single-layer GEM histories inside a programmable bx window, picks the
// youngest free matching entry, consumes it and registers one match flag.
module gemcsc_match_window
  import gemcsc_match_window_pkg::*;
(
  input  logic              clock,
  input  logic              global_reset,
  input  logic              flush,
  input  logic [WIN_W-1:0]  gem_win,
  input  logic              alct_vld,
  input  logic [MXWG-1:0]   alct_wg,
  input  logic              clct_vld,
  input  logic [MXHS-1:0]   clct_hs,
  input  logic              copad_vld,
  input  logic [MXWG-1:0]   copad_wg_lo,
  input  logic [MXWG-1:0]   copad_wg_hi,
  input  logic [MXHS-1:0]   copad_hs_lo,
  input  logic [MXHS-1:0]   copad_hs_hi,
  input  logic              gem_vld,
  input  logic [MXWG-1:0]   gem_wg_lo,
  input  logic [MXWG-1:0]   gem_wg_hi,
  input  logic [MXHS-1:0]   gem_hs_lo,
  input  logic [MXHS-1:0]   gem_hs_hi,
  output logic              alct_clct_copad_match,
  output logic              alct_clct_gem_match,
  output logic              alct_clct_match,
  output logic              clct_copad_match,
  output logic              alct_copad_match,
  output logic [AGE_W-1:0]  match_age,
  output logic              match_vld
);

  // Consume mask for ages that survive the shift: youngest set bit only.
  // An entry at the oldest age needs no mark since it falls off anyway.
  function automatic logic [MXHIST-2:0] youngest_consume(input logic [MXHIST-1:0] m);
    logic [MXHIST-2:0] res;
    res = '0;
    for (int k = MXHIST-2; k >= 0; k--) begin
      if (m[k]) begin
        res    = '0;
        res[k] = 1'b1;
      end
    end
    return res;
  endfunction

  // Age of the youngest set bit (0 when none).
  function automatic logic [AGE_W-1:0] youngest_age(input logic [MXHIST-1:0] m);
    logic [AGE_W-1:0] a;
    a = '0;
    for (int k = MXHIST-1; k >= 0; k--) begin
      if (m[k]) a = AGE_W'(k);
    end
    return a;
  endfunction

  entry_t                copad_in, gem_in;
  entry_t [MXHIST-1:0]   copad_hist, gem_hist;
  logic   [MXHIST-2:0]   copad_consume, gem_consume;

  logic   [31:0]         win_ext, win_lim;
  logic   [MXHIST-1:0]   cp_elig, cp_wg, cp_hs;
  logic   [MXHIST-1:0]   gm_elig, gm_wg, gm_hs;
  logic   [MXHIST-1:0]   cp_full, cp_wg_m, cp_hs_m, gm_full;

  flag_e                 flag_d, flag_p1;
  logic   [AGE_W-1:0]    age_d, age_p1;

  assign copad_in.vld        = copad_vld;
  assign copad_in.used       = 1'b0;
  assign copad_in.span.wg_lo = copad_wg_lo;
  assign copad_in.span.wg_hi = copad_wg_hi;
  assign copad_in.span.hs_lo = copad_hs_lo;
  assign copad_in.span.hs_hi = copad_hs_hi;

  assign gem_in.vld          = gem_vld;
  assign gem_in.used         = 1'b0;
  assign gem_in.span.wg_lo   = gem_wg_lo;
  assign gem_in.span.wg_hi   = gem_wg_hi;
  assign gem_in.span.hs_lo   = gem_hs_lo;
  assign gem_in.span.hs_hi   = gem_hs_hi;

  gemcsc_match_window_hist u_copad_hist (
    .clock        (clock),
    .global_reset (global_reset),
    .flush        (flush),
    .entry        (copad_in),
    .consume      (copad_consume),
    .hist         (copad_hist)
  );

  gemcsc_match_window_hist u_gem_hist (
    .clock        (clock),
    .global_reset (global_reset),
    .flush        (flush),
    .entry        (gem_in),
    .consume      (gem_consume),
    .hist         (gem_hist)
  );

  // Window clamp and per-entry eligibility / span comparators.
  always_comb begin
    win_ext = {{(32-WIN_W){1'b0}}, gem_win};
    win_lim = (win_ext >= 32'(MXHIST)) ? 32'(MXHIST-1) : win_ext;
    for (int k = 0; k < MXHIST; k++) begin
      cp_elig[k] = copad_hist[k].vld && !copad_hist[k].used && ($unsigned(k) <= win_lim);
      gm_elig[k] = gem_hist[k].vld && !gem_hist[k].used && ($unsigned(k) <= win_lim);
      cp_wg[k]   = wg_in_span(copad_hist[k].span.wg_lo, copad_hist[k].span.wg_hi, alct_wg);
      cp_hs[k]   = hs_in_span(copad_hist[k].span.hs_lo, copad_hist[k].span.hs_hi, clct_hs);
      gm_wg[k]   = wg_in_span(gem_hist[k].span.wg_lo, gem_hist[k].span.wg_hi, alct_wg);
      gm_hs[k]   = hs_in_span(gem_hist[k].span.hs_lo, gem_hist[k].span.hs_hi, clct_hs);
    end
    cp_full = cp_elig & cp_wg & cp_hs;
    cp_wg_m = cp_elig & cp_wg;
    cp_hs_m = cp_elig & cp_hs;
    gm_full = gm_elig & gm_wg & gm_hs;
  end

  // Priority encoder: one flag per bx and the entry it consumes.
  always_comb begin
    flag_d        = FLAG_NONE;
    age_d         = '0;
    copad_consume = '0;
    gem_consume   = '0;
    if (alct_vld && clct_vld) begin
      if (|cp_full) begin
        flag_d        = FLAG_ALCT_CLCT_COPAD;
        age_d         = youngest_age(cp_full);
        copad_consume = youngest_consume(cp_full);
      end else if (|gm_full) begin
        flag_d        = FLAG_ALCT_CLCT_GEM;
        age_d         = youngest_age(gm_full);
        gem_consume   = youngest_consume(gm_full);
      end else begin
        flag_d        = FLAG_ALCT_CLCT;
      end
    end else if (clct_vld && (|cp_hs_m)) begin
      flag_d        = FLAG_CLCT_COPAD;
      age_d         = youngest_age(cp_hs_m);
      copad_consume = youngest_consume(cp_hs_m);
    end else if (alct_vld && (|cp_wg_m)) begin
      flag_d        = FLAG_ALCT_COPAD;
      age_d         = youngest_age(cp_wg_m);
      copad_consume = youngest_consume(cp_wg_m);
    end
  end

  // ---- stage p1: registered flag code and consumed-entry age ----
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      flag_p1 <= FLAG_NONE;
      age_p1  <= '0;
    end else begin
      flag_p1 <= flag_d;
      age_p1  <= age_d;
    end
  end

  assign alct_clct_copad_match = (flag_p1 == FLAG_ALCT_CLCT_COPAD);
  assign alct_clct_gem_match   = (flag_p1 == FLAG_ALCT_CLCT_GEM);
  assign alct_clct_match       = (flag_p1 == FLAG_ALCT_CLCT);
  assign clct_copad_match      = (flag_p1 == FLAG_CLCT_COPAD);
  assign alct_copad_match      = (flag_p1 == FLAG_ALCT_COPAD);
  assign match_age             = age_p1;
  assign match_vld             = (flag_p1 != FLAG_NONE);

endmodule
